glitch_sequencer: RTL and testbench

Parametrised successor to the single offset/duration glitch chain. It stores up to NUM_PULSES (offset, width) pairs and, once armed, fires a programmable train of glitch pulses after a trigger edge. The command processor writes the table and the target-reset logic supplies the trigger. The registered active-low output feeds the power_ctrl tri-state buffer.

---
 rtl/glitch_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_glitch_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/glitch_sequencer.sv
// Table-driven glitch pulse train fired from a trigger rising edge.
// Optional feature macro GLITCH_ARM_TIMEOUT_EN: ARMED gives up after ARM_TIMEOUT cycles.
//
// state  | meaning
// IDLE   | table and count writable, waiting for arm
// ARMED  | waiting for trigger rising edge
// OFFSET | counting offset; for entries after the first this includes the gap cycle
// PULSE  | glitch output held low
// DONE   | one-cycle completion strobe
module glitch_sequencer #(
  parameter int NUM_PULSES  = 4,
  parameter int CNT_W       = 32,
  parameter int ARM_TIMEOUT = 100000000,
  localparam int IDX_W      = (NUM_PULSES > 1) ? $clog2(NUM_PULSES) : 1,
  localparam int CIDX_W     = $clog2(NUM_PULSES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [CNT_W-1:0]  cfg_offset,
  input  logic [CNT_W-1:0]  cfg_width,
  input  logic              cfg_count_we,
  input  logic [CIDX_W-1:0] cfg_count,
  input  logic              arm,
  input  logic              abort,
  input  logic              trigger,
  output logic              glitch_active_low,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [IDX_W-1:0]  pulse_idx
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [2:0] {IDLE, ARMED, OFFSET, PULSE, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  off_tab [DEPTH];
  logic [CNT_W-1:0]  wid_tab [DEPTH];
  logic [CIDX_W-1:0] count;
  logic [CNT_W-1:0]  cnt;
  logic              trig_q;
  logic              trig_rise;
  logic              last_entry;
  logic              entry_end;
  logic [IDX_W-1:0]  nxt_idx;
`ifdef GLITCH_ARM_TIMEOUT_EN
  localparam int TMO_W = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
  logic [TMO_W-1:0]  tmo_cnt;
`endif

  assign trig_rise  = trigger & ~trig_q;
  assign nxt_idx    = pulse_idx + 1'b1;
  assign last_entry = (int'(pulse_idx) + 1) >= int'(count);

  // Current entry finishes this cycle; the next cycle is the following
  // entry's reference (gap) cycle or DONE.
  always_comb begin
    entry_end = 1'b0;
    case (state)
      ARMED:   entry_end = trig_rise && (count != '0) &&
                           (off_tab[0] == '0) && (wid_tab[0] == '0);
      OFFSET:  entry_end = (cnt == '0) && (wid_tab[pulse_idx] == '0);
      PULSE:   entry_end = (cnt == '0);
      default: entry_end = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      glitch_active_low <= 1'b1;
      busy              <= 1'b0;
      done              <= 1'b0;
      timeout           <= 1'b0;
      pulse_idx         <= '0;
      count             <= CIDX_W'(1);
      cnt               <= '0;
      trig_q            <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        off_tab[i] <= '0;
        wid_tab[i] <= '0;
      end
`ifdef GLITCH_ARM_TIMEOUT_EN
      tmo_cnt           <= '0;
`endif
    end else begin
      trig_q  <= trigger;
      done    <= 1'b0;
      timeout <= 1'b0;

      if (state == IDLE) begin
        if (cfg_we && (int'(cfg_idx) < NUM_PULSES)) begin
          off_tab[cfg_idx] <= cfg_offset;
          wid_tab[cfg_idx] <= cfg_width;
        end
        if (cfg_count_we)
          count <= (int'(cfg_count) > NUM_PULSES) ? CIDX_W'(NUM_PULSES) : cfg_count;
      end

      if (abort) begin
        state             <= IDLE;
        glitch_active_low <= 1'b1;
        busy              <= 1'b0;
        pulse_idx         <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (arm) begin
              state <= ARMED;
              busy  <= 1'b1;
`ifdef GLITCH_ARM_TIMEOUT_EN
              tmo_cnt <= TMO_W'(ARM_TIMEOUT - 1);
`endif
            end
          end
          ARMED: begin
            if (trig_rise) begin
              if (count == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else if (off_tab[0] != '0) begin
                // The edge cycle is entry 0's reference, so one offset cycle is already spent.
                state <= OFFSET;
                cnt   <= off_tab[0] - 1'b1;
              end else if (wid_tab[0] != '0) begin
                state             <= PULSE;
                cnt               <= wid_tab[0] - 1'b1;
                glitch_active_low <= 1'b0;
              end
            end
`ifdef GLITCH_ARM_TIMEOUT_EN
            else if (tmo_cnt == '0) begin
              state   <= IDLE;
              busy    <= 1'b0;
              timeout <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt - 1'b1;
            end
`endif
          end
          OFFSET: begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else if (wid_tab[pulse_idx] != '0) begin
              state             <= PULSE;
              cnt               <= wid_tab[pulse_idx] - 1'b1;
              glitch_active_low <= 1'b0;
            end
          end
          PULSE: begin
            if (cnt != '0)
              cnt <= cnt - 1'b1;
          end
          DONE: begin
            state     <= IDLE;
            busy      <= 1'b0;
            pulse_idx <= '0;
          end
          default: state <= IDLE;
        endcase

        if (entry_end) begin
          glitch_active_low <= 1'b1;
          if (last_entry) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state     <= OFFSET;
            pulse_idx <= nxt_idx;
            cnt       <= off_tab[nxt_idx];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_glitch_sequencer.sv
// Scoreboard bench for glitch_sequencer: a pulse-list model predicts low
// intervals and strobes, a negedge monitor compares what the DUT produces.
module tb_glitch_sequencer;

  localparam int NP = 4;
  localparam int K_PULSE = 0;
  localparam int K_DONE  = 1;
  localparam int K_TMO   = 2;

  typedef struct {
    int kind;
    int cyc;
    int len;
    int idx;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [31:0] cfg_offset = '0;
  logic [31:0] cfg_width = '0;
  logic        cfg_count_we = 1'b0;
  logic [2:0]  cfg_count = '0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic        trigger = 1'b1;
  logic        glitch_active_low;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [1:0]  pulse_idx;

  glitch_sequencer #(.NUM_PULSES(NP), .CNT_W(32), .ARM_TIMEOUT(20)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_offset(cfg_offset), .cfg_width(cfg_width),
    .cfg_count_we(cfg_count_we), .cfg_count(cfg_count),
    .arm(arm), .abort(abort), .trigger(trigger),
    .glitch_active_low(glitch_active_low), .busy(busy), .done(done),
    .timeout(timeout), .pulse_idx(pulse_idx)
  );

  always #5 clk = ~clk;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  ev_t exp_q[$];
  int  m_off [NP];
  int  m_wid [NP];
  int  m_count = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, longint got, longint expv);
    n_checks++;
    if (got == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, expv, cyc);
  endtask

  task automatic got_event(int kind, int c, int len, int idx);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected no event", kind, c);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind", kind, e.kind);
      check("ev_cycle", c, e.cyc);
      check("ev_len", len, e.len);
      check("ev_idx", idx, e.idx);
    end
  endtask

  // Monitor: a low interval is reported when it ends, strobes when seen.
  logic prev_g = 1'b1;
  int   start_c = 0;
  int   start_idx = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (!glitch_active_low && prev_g) begin
        start_c   <= cyc;
        start_idx <= int'(pulse_idx);
      end
      if (glitch_active_low && !prev_g) got_event(K_PULSE, start_c, cyc - start_c, start_idx);
      if (done)    got_event(K_DONE, cyc, 0, int'(pulse_idx));
      if (timeout) got_event(K_TMO, cyc, 0, int'(pulse_idx));
    end
    prev_g <= glitch_active_low;
  end

  function automatic void push_ev(int kind, int c, int len, int idx);
    ev_t e;
    e.kind = kind; e.cyc = c; e.len = len; e.idx = idx;
    exp_q.push_back(e);
  endfunction

  // Reference: each entry occupies offset+width cycles after its reference
  // cycle; the next reference (or done) follows immediately.
  function automatic void push_expected(int e);
    int r = e;
    if (m_count == 0) begin
      push_ev(K_DONE, e + 1, 0, 0);
    end else begin
      for (int i = 0; i < m_count; i++) begin
        if (m_wid[i] > 0) push_ev(K_PULSE, r + 1 + m_off[i], m_wid[i], i);
        r = r + m_off[i] + m_wid[i] + 1;
      end
      push_ev(K_DONE, r, 0, m_count - 1);
    end
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_entry(int i, int o, int w, bit upd);
    cfg_we = 1'b1; cfg_idx = 2'(i); cfg_offset = 32'(o); cfg_width = 32'(w);
    tick();
    cfg_we = 1'b0;
    if (upd) begin m_off[i] = o; m_wid[i] = w; end
  endtask

  task automatic write_count(int c, bit upd);
    cfg_count_we = 1'b1; cfg_count = 3'(c);
    tick();
    cfg_count_we = 1'b0;
    if (upd) m_count = (c > NP) ? NP : c;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    check("seq_complete", longint'(exp_q.size() == 0 && !busy), 1);
  endtask

  task automatic run_seq(bit busy_write);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    if (busy_write) begin
      write_entry(0, 1, 1, 1'b0);
      write_count(2, 1'b0);
    end
    repeat ($urandom_range(0, 5)) tick();
    trigger = 1'b1;
    push_expected(cyc);
    tick();
    trigger = 1'b0;
    wait_idle(400);
  endtask

  initial begin
    int e;
    for (int i = 0; i < NP; i++) begin m_off[i] = 0; m_wid[i] = 0; end

    // Reset with trigger held high
    tick();
    check("rst_glitch", glitch_active_low, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_pulse_idx", pulse_idx, 0);
    rst = 1'b0;
    tick();

    // Trigger still high while armed: no edge until it falls and rises
    arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (5) tick();
    check("armed_busy", busy, 1);
    check("armed_no_pulse", glitch_active_low, 1);
    trigger = 1'b0;
    tick();
    trigger = 1'b1;
    push_expected(cyc);
    tick();
    trigger = 1'b0;
    wait_idle(100);

    // Single pulse
    write_entry(0, 10, 5, 1'b1);
    write_count(1, 1'b1);
    run_seq(1'b0);

    // Three-pulse train with a zero offset and a zero width
    write_entry(0, 2, 3, 1'b1);
    write_entry(1, 0, 1, 1'b1);
    write_entry(2, 4, 0, 1'b1);
    write_count(3, 1'b1);
    run_seq(1'b0);

    // Abort during the second low cycle, then replay the same table
    write_entry(0, 3, 4, 1'b1);
    write_count(1, 1'b1);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    trigger = 1'b1;
    e = cyc;
    push_ev(K_PULSE, e + 4, 2, 0);
    tick();
    trigger = 1'b0;
    while (cyc < e + 5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_glitch", glitch_active_low, 1);
    repeat (20) tick();
    wait_idle(50);
    run_seq(1'b0);

    // Writes while busy are ignored
    run_seq(1'b1);

    // Count clamp: 7 requested, four entries fire
    write_entry(0, 1, 2, 1'b1);
    write_entry(1, 0, 1, 1'b1);
    write_entry(2, 2, 2, 1'b1);
    write_entry(3, 3, 1, 1'b1);
    write_count(7, 1'b1);
    run_seq(1'b0);

    // Randomized tables and counts
    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < NP; i++)
        write_entry(i, int'($urandom_range(0, 6)), int'($urandom_range(0, 4)), 1'b1);
      write_count(int'($urandom_range(0, 7)), 1'b1);
      run_seq(1'b0);
    end

`ifdef GLITCH_ARM_TIMEOUT_EN
    arm = 1'b1;
    push_ev(K_TMO, cyc + 21, 0, 0);
    tick();
    arm = 1'b0;
    wait_idle(100);
`else
    arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (1000) tick();
    check("no_timeout_busy", busy, 1);
    check("no_timeout_strobe", timeout, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_from_armed", busy, 0);
`endif

    repeat (10) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
